// File: rtl/id_stage_if.sv
// Signal bundle around the decode stage: IF/ID inputs, EX hazard/stall inputs,
// the write-back port and the registered ID/EX outputs.
interface id_stage_if #(
  parameter int DATA_W = 16
);
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [DATA_W-1:0] if_pc_inc;
  logic              ex_stall;
  logic              flush;
  logic              ex_mem_read;
  logic [3:0]        ex_rd;
  logic              wb_we;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              id_stall;
  logic              halted;
  logic              idex_valid;
  logic [DATA_W-1:0] idex_pc_inc;
  logic [DATA_W-1:0] idex_r0data;
  logic [DATA_W-1:0] idex_r1data;
  logic [DATA_W-1:0] idex_imm;
  logic [DATA_W-1:0] idex_offset;
  logic [DATA_W-1:0] idex_call_tgt;
  logic [3:0]        idex_rs;
  logic [3:0]        idex_rt;
  logic [3:0]        idex_rd;
  logic [8:0]        idex_ex;
  logic [2:0]        idex_m;
  logic [2:0]        idex_wb;

  modport master (
    output if_valid, if_instr, if_pc_inc, ex_stall, flush, ex_mem_read, ex_rd,
           wb_we, wb_addr, wb_data,
    input  id_stall, halted, idex_valid, idex_pc_inc, idex_r0data, idex_r1data,
           idex_imm, idex_offset, idex_call_tgt, idex_rs, idex_rt, idex_rd,
           idex_ex, idex_m, idex_wb
  );

  modport slave (
    input  if_valid, if_instr, if_pc_inc, ex_stall, flush, ex_mem_read, ex_rd,
           wb_we, wb_addr, wb_data,
    output id_stall, halted, idex_valid, idex_pc_inc, idex_r0data, idex_r1data,
           idex_imm, idex_offset, idex_call_tgt, idex_rs, idex_rt, idex_rd,
           idex_ex, idex_m, idex_wb
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-through bypass, instruction decoder,
// load-use hazard detection, registered ID/EX boundary and sticky halt FSM.
module id_stage_pipe #(
  parameter int                DATA_W   = 16,
  parameter int                NREGS    = 16,
  parameter int                SP_REG   = 14,
  parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(16'hFFFF)
) (
  input  logic     clk,
  input  logic     rst_n,
  id_stage_if.slave bus
);

  localparam int            AW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW-1:0] SP_A = AW'(SP_REG);

  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] r0data;
    logic [DATA_W-1:0] r1data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] call_tgt;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [3:0]        rd;
    logic [8:0]        ex;
    logic [2:0]        m;
    logic [2:0]        wb;
  } idex_t;

  function automatic logic [DATA_W-1:0] sext4(input logic [3:0] v);
    return {{(DATA_W-4){v[3]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
    return {{(DATA_W-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
    return {{(DATA_W-8){1'b0}}, v};
  endfunction

  logic [DATA_W-1:0] regs [0:NREGS-1];

  logic [3:0] opcode;
  logic       reg_write, mem_read, mem_write, mem_to_reg, branch;
  logic       call_op, ret_op, pc_to_mem, sp_addr, read_rd;
  logic       use_r0, use_r1, is_halt, imm_byte;
  logic [1:0] alu_src;
  logic [3:0] alu_op;

  logic [AW-1:0]     r0_addr, r1_addr, wb_a, ex_a;
  logic              wb_fire, hazard, halt_take;
  logic [DATA_W-1:0] r0_data, r1_data;

  idex_t  dec_p0;
  idex_t  idex_p1;
  state_t state_p1;
  logic   halted_p1;

  assign opcode = bus.if_instr[15:12];

  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    call_op    = 1'b0;
    ret_op     = 1'b0;
    pc_to_mem  = 1'b0;
    sp_addr    = 1'b0;
    read_rd    = 1'b0;
    use_r0     = 1'b0;
    use_r1     = 1'b0;
    is_halt    = 1'b0;
    imm_byte   = 1'b0;
    alu_src    = 2'b00;
    alu_op     = 4'h0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        reg_write = 1'b1;
        alu_op    = opcode;
        use_r0    = 1'b1;
        use_r1    = 1'b1;
      end
      4'h4: begin
        reg_write = 1'b1;
        alu_src   = 2'b01;
        use_r0    = 1'b1;
      end
      4'h5, 4'h6, 4'h7: begin
        reg_write = 1'b1;
        alu_src   = 2'b01;
        alu_op    = opcode;
        use_r0    = 1'b1;
      end
      4'h8: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 2'b01;
        use_r0     = 1'b1;
      end
      4'h9: begin
        mem_write = 1'b1;
        alu_src   = 2'b01;
        read_rd   = 1'b1;
        use_r0    = 1'b1;
        use_r1    = 1'b1;
      end
      4'hA, 4'hB: begin
        // rd is read so EX can keep the untouched half of the register
        reg_write = 1'b1;
        alu_src   = 2'b10;
        alu_op    = opcode;
        read_rd   = 1'b1;
        use_r1    = 1'b1;
        imm_byte  = 1'b1;
      end
      4'hC: branch = 1'b1;
      4'hD: begin
        reg_write = 1'b1;
        mem_write = 1'b1;
        pc_to_mem = 1'b1;
        sp_addr   = 1'b1;
        call_op   = 1'b1;
        alu_src   = 2'b11;
        alu_op    = 4'h1;
        use_r0    = 1'b1;
      end
      4'hE: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
        sp_addr   = 1'b1;
        ret_op    = 1'b1;
        alu_src   = 2'b11;
        use_r0    = 1'b1;
      end
      default: is_halt = 1'b1;
    endcase
  end

  assign r0_addr = sp_addr ? SP_A : bus.if_instr[4 +: AW];
  assign r1_addr = read_rd ? bus.if_instr[8 +: AW] : bus.if_instr[0 +: AW];
  assign wb_a    = bus.wb_addr[AW-1:0];
  assign ex_a    = bus.ex_rd[AW-1:0];
  assign wb_fire = bus.wb_we && (wb_a != '0);

  always_comb begin
    r0_data = regs[r0_addr];
    if (r0_addr == '0)
      r0_data = '0;
    else if (wb_fire && (wb_a == r0_addr))
      r0_data = bus.wb_data;
  end

  always_comb begin
    r1_data = regs[r1_addr];
    if (r1_addr == '0)
      r1_data = '0;
    else if (wb_fire && (wb_a == r1_addr))
      r1_data = bus.wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (i == SP_REG) ? SP_RESET : '0;
    end else if (wb_fire) begin
      regs[wb_a] <= bus.wb_data;
    end
  end

  assign hazard = bus.if_valid && bus.ex_mem_read && (ex_a != '0) &&
                  ((use_r0 && (r0_addr == ex_a)) || (use_r1 && (r1_addr == ex_a)));

  assign halt_take = (state_p1 == S_RUN) && bus.if_valid && is_halt &&
                     !bus.flush && !bus.ex_stall && !hazard;

  // Halted freezes fetch regardless of flush; reset always releases the stall.
  assign bus.id_stall = rst_n && ((state_p1 == S_HALTED) ||
                                  ((hazard || bus.ex_stall) && !bus.flush));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= S_RUN;
      halted_p1 <= 1'b0;
    end else begin
      case (state_p1)
        S_RUN: begin
          if (halt_take) begin
            state_p1  <= S_HALTED;
            halted_p1 <= 1'b1;
          end
        end
        S_HALTED: begin
          state_p1  <= S_HALTED;
          halted_p1 <= 1'b1;
        end
      endcase
    end
  end

  assign bus.halted = halted_p1;

  always_comb begin
    dec_p0          = '0;
    dec_p0.valid    = bus.if_valid;
    dec_p0.pc_inc   = bus.if_pc_inc;
    dec_p0.r0data   = r0_data;
    dec_p0.r1data   = r1_data;
    dec_p0.imm      = imm_byte ? zext8(bus.if_instr[7:0]) : sext4(bus.if_instr[3:0]);
    dec_p0.offset   = sext8(bus.if_instr[7:0]);
    dec_p0.call_tgt = {bus.if_pc_inc[DATA_W-1:12], bus.if_instr[11:0]};
    dec_p0.rs       = bus.if_instr[7:4];
    dec_p0.rt       = bus.if_instr[3:0];
    dec_p0.rd       = bus.if_instr[11:8];
    if (bus.if_valid) begin
      dec_p0.ex = {call_op, pc_to_mem, sp_addr, alu_src, alu_op};
      dec_p0.m  = {branch, mem_write, mem_read};
      dec_p0.wb = {ret_op, mem_to_reg, reg_write};
    end
  end

  // ID/EX boundary: flush beats stall, stall beats hazard/halt bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_p1 <= '0;
    end else if (bus.flush) begin
      idex_p1 <= '0;
    end else if (!bus.ex_stall) begin
      if (hazard || (state_p1 == S_HALTED) || (bus.if_valid && is_halt))
        idex_p1 <= '0;
      else
        idex_p1 <= dec_p0;
    end
  end

  assign bus.idex_valid    = idex_p1.valid;
  assign bus.idex_pc_inc   = idex_p1.pc_inc;
  assign bus.idex_r0data   = idex_p1.r0data;
  assign bus.idex_r1data   = idex_p1.r1data;
  assign bus.idex_imm      = idex_p1.imm;
  assign bus.idex_offset   = idex_p1.offset;
  assign bus.idex_call_tgt = idex_p1.call_tgt;
  assign bus.idex_rs       = idex_p1.rs;
  assign bus.idex_rt       = idex_p1.rt;
  assign bus.idex_rd       = idex_p1.rd;
  assign bus.idex_ex       = idex_p1.ex;
  assign bus.idex_m        = idex_p1.m;
  assign bus.idex_wb       = idex_p1.wb;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an instruction-level model.
module tb_id_stage_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_stage_if #(.DATA_W(16)) bus ();

  id_stage_pipe #(
    .DATA_W(16), .NREGS(16), .SP_REG(14), .SP_RESET(16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        valid;
    logic [15:0] pc, r0, r1, imm, off, tgt;
    logic [3:0]  rs, rt, rd;
    logic [8:0]  ex;
    logic [2:0]  m, wb;
  } exp_t;

  int vectors     = 0;
  int miscompares = 0;

  logic        s_valid, s_stall, s_flush, s_mr, s_we;
  logic [15:0] s_instr, s_pc, s_wd;
  logic [3:0]  s_exrd, s_wa;

  logic [15:0] mreg [16];
  exp_t        e;
  logic        mhalted;
  logic        stall_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    s_valid = 0; s_instr = 16'h0; s_pc = 16'h0; s_stall = 0; s_flush = 0;
    s_mr = 0; s_exrd = 4'h0; s_we = 0; s_wa = 4'h0; s_wd = 16'h0;
  endtask

  task automatic apply_stim();
    bus.if_valid = s_valid;  bus.if_instr = s_instr;  bus.if_pc_inc = s_pc;
    bus.ex_stall = s_stall;  bus.flush = s_flush;     bus.ex_mem_read = s_mr;
    bus.ex_rd = s_exrd;      bus.wb_we = s_we;        bus.wb_addr = s_wa;
    bus.wb_data = s_wd;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
    mreg[14] = 16'hFFFF;
    e = '0;
    mhalted = 0;
  endtask

  // Per-opcode control table: ex/m/wb literals, which read ports matter,
  // whether port 0 is the stack pointer and whether port 1 reads rd.
  task automatic spec_ctl(input logic [3:0] op, output logic [8:0] ex, output logic [2:0] m,
                          output logic [2:0] wb, output logic u0, output logic u1,
                          output logic sps, output logic rds);
    ex = 9'h0; m = 3'b000; wb = 3'b000; u0 = 0; u1 = 0; sps = 0; rds = 0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin ex = {5'b00000, op}; wb = 3'b001; u0 = 1; u1 = 1; end
      4'h4:                   begin ex = 9'b000_01_0000; wb = 3'b001; u0 = 1; end
      4'h5, 4'h6, 4'h7:       begin ex = {5'b00001, op}; wb = 3'b001; u0 = 1; end
      4'h8:                   begin ex = 9'b000_01_0000; m = 3'b001; wb = 3'b011; u0 = 1; end
      4'h9:                   begin ex = 9'b000_01_0000; m = 3'b010; u0 = 1; u1 = 1; rds = 1; end
      4'hA, 4'hB:             begin ex = {5'b00010, op}; wb = 3'b001; u1 = 1; rds = 1; end
      4'hC:                   begin m = 3'b100; end
      4'hD:                   begin ex = 9'b111_11_0001; m = 3'b010; wb = 3'b001; u0 = 1; sps = 1; end
      4'hE:                   begin ex = 9'b001_11_0000; m = 3'b001; wb = 3'b101; u0 = 1; sps = 1; end
      default: ;
    endcase
  endtask

  function automatic logic [15:0] mread(input logic [3:0] a);
    if (a == 4'h0) return 16'h0;
    if (s_we && s_wa == a) return s_wd;
    return mreg[a];
  endfunction

  task automatic check_outputs();
    chk("idex_valid", 32'(bus.idex_valid), 32'(e.valid));
    chk("idex_pc_inc", 32'(bus.idex_pc_inc), 32'(e.pc));
    chk("idex_r0data", 32'(bus.idex_r0data), 32'(e.r0));
    chk("idex_r1data", 32'(bus.idex_r1data), 32'(e.r1));
    chk("idex_imm", 32'(bus.idex_imm), 32'(e.imm));
    chk("idex_offset", 32'(bus.idex_offset), 32'(e.off));
    chk("idex_call_tgt", 32'(bus.idex_call_tgt), 32'(e.tgt));
    chk("idex_rs", 32'(bus.idex_rs), 32'(e.rs));
    chk("idex_rt", 32'(bus.idex_rt), 32'(e.rt));
    chk("idex_rd", 32'(bus.idex_rd), 32'(e.rd));
    chk("idex_ex", 32'(bus.idex_ex), 32'(e.ex));
    chk("idex_m", 32'(bus.idex_m), 32'(e.m));
    chk("idex_wb", 32'(bus.idex_wb), 32'(e.wb));
    chk("halted", 32'(bus.halted), 32'(mhalted));
  endtask

  // One cycle: check registered outputs, drive stimulus, check id_stall,
  // advance the model across the rising edge.
  task automatic step();
    logic [3:0]  op;
    logic [8:0]  cex;
    logic [2:0]  cm, cwb;
    logic        u0, u1, sps, rds, haz, xstall, nh;
    logic [3:0]  r0a, r1a;
    exp_t        nx;
    check_outputs();
    apply_stim();
    #1;
    op = s_instr[15:12];
    spec_ctl(op, cex, cm, cwb, u0, u1, sps, rds);
    r0a = sps ? 4'd14 : s_instr[7:4];
    r1a = rds ? s_instr[11:8] : s_instr[3:0];
    haz = s_valid && s_mr && (s_exrd != 4'h0) &&
          ((u0 && r0a == s_exrd) || (u1 && r1a == s_exrd));
    xstall = mhalted ? 1'b1 : (s_flush ? 1'b0 : (haz || s_stall));
    stall_seen = bus.id_stall;
    chk("id_stall", 32'(bus.id_stall), 32'(xstall));
    nx = e;
    nh = mhalted;
    if (s_flush) nx = '0;
    else if (s_stall) nx = e;
    else if (haz || mhalted || (s_valid && op == 4'hF)) begin
      nx = '0;
      if (s_valid && op == 4'hF) nh = 1'b1;
    end else begin
      nx.valid = s_valid;
      nx.pc    = s_pc;
      nx.r0    = mread(r0a);
      nx.r1    = mread(r1a);
      nx.imm   = (op == 4'hA || op == 4'hB) ? {8'h00, s_instr[7:0]} : {{12{s_instr[3]}}, s_instr[3:0]};
      nx.off   = {{8{s_instr[7]}}, s_instr[7:0]};
      nx.tgt   = {s_pc[15:12], s_instr[11:0]};
      nx.rs    = s_instr[7:4];
      nx.rt    = s_instr[3:0];
      nx.rd    = s_instr[11:8];
      nx.ex    = s_valid ? cex : 9'h0;
      nx.m     = s_valid ? cm : 3'h0;
      nx.wb    = s_valid ? cwb : 3'h0;
    end
    @(posedge clk);
    #1;
    if (s_we && s_wa != 4'h0) mreg[s_wa] = s_wd;
    e = nx;
    mhalted = nh;
  endtask

  task automatic do_reset();
    apply_stim();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_id_stall", 32'(bus.id_stall), 32'h0);
    chk("rst_idex_valid", 32'(bus.idex_valid), 32'h0);
    chk("rst_idex_ex", 32'(bus.idex_ex), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_stim();
    logic [3:0]  op;
    logic [11:0] f;
    op = ($urandom_range(0, 99) < 2) ? 4'hF : 4'($urandom_range(0, 14));
    f  = 12'($urandom);
    if ($urandom_range(0, 3) != 0) f = f & 12'h333;
    s_instr = {op, f};
    s_valid = ($urandom_range(0, 99) < 85);
    s_pc    = 16'($urandom);
    s_stall = ($urandom_range(0, 99) < 15);
    s_flush = mhalted ? 1'b0 : ($urandom_range(0, 99) < 8);
    s_mr    = ($urandom_range(0, 99) < 35);
    s_exrd  = ($urandom_range(0, 4) == 0) ? 4'd14 : 4'($urandom_range(0, 3));
    s_we    = ($urandom_range(0, 1) == 1);
    s_wa    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    s_wd    = 16'($urandom);
  endtask

  initial begin
    int halt_cycles;
    set_idle();
    apply_stim();
    #1;
    rst_n = 1'b0;
    model_reset();
    #10;
    chk("reset_idex_valid", 32'(bus.idex_valid), 32'h0);
    chk("reset_halted", 32'(bus.halted), 32'h0);
    chk("reset_id_stall", 32'(bus.id_stall), 32'h0);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Preload r1=5, r2=7, then ADD r3,r1,r2
    set_idle(); s_we = 1; s_wa = 4'd1; s_wd = 16'd5; step();
    s_wa = 4'd2; s_wd = 16'd7; step();
    set_idle(); s_valid = 1; s_instr = 16'h0312; s_pc = 16'h0010; step();
    chk("add_valid", 32'(bus.idex_valid), 32'h1);
    chk("add_r0data", 32'(bus.idex_r0data), 32'h5);
    chk("add_r1data", 32'(bus.idex_r1data), 32'h7);
    chk("add_wb", 32'(bus.idex_wb), 32'h1);
    chk("add_alu_op", 32'(bus.idex_ex[3:0]), 32'h0);

    // Same-cycle write of r4 seen by XOR r5,r4,r4
    s_instr = 16'h3544; s_we = 1; s_wa = 4'd4; s_wd = 16'h1234; step();
    chk("bypass_r0data", 32'(bus.idex_r0data), 32'h1234);
    chk("bypass_r1data", 32'(bus.idex_r1data), 32'h1234);

    // Writing r0 has no effect: ADD r6,r0,r0
    s_instr = 16'h0600; s_we = 1; s_wa = 4'd0; s_wd = 16'd9; step();
    chk("r0_bypass_zero", 32'(bus.idex_r0data), 32'h0);
    s_we = 0; step();
    chk("r0_read_zero", 32'(bus.idex_r0data), 32'h0);

    // Load-use hazard on r2 for SUB r1,r2,r3
    set_idle(); s_valid = 1; s_instr = 16'h1123; s_mr = 1; s_exrd = 4'd2; step();
    chk("haz_stall", 32'(stall_seen), 32'h1);
    chk("haz_bubble", 32'(bus.idex_valid), 32'h0);
    s_mr = 0; step();
    chk("haz_release_stall", 32'(stall_seen), 32'h0);
    chk("haz_issue_valid", 32'(bus.idex_valid), 32'h1);
    chk("haz_issue_alu_op", 32'(bus.idex_ex[3:0]), 32'h1);
    chk("haz_issue_r0data", 32'(bus.idex_r0data), 32'h7);

    // flush with hazard, flush with HALT
    s_mr = 1; s_flush = 1; step();
    chk("flush_haz_stall", 32'(stall_seen), 32'h0);
    chk("flush_haz_bubble", 32'(bus.idex_valid), 32'h0);
    set_idle(); s_valid = 1; s_instr = 16'hF000; s_flush = 1; step();
    set_idle(); step();
    chk("flush_halt_not_taken", 32'(bus.halted), 32'h0);

    // CALL 0xABC, then two EX stall cycles hold ID/EX
    set_idle(); s_valid = 1; s_instr = 16'hDABC; s_pc = 16'h5001; step();
    chk("call_r0data", 32'(bus.idex_r0data), 32'hFFFF);
    chk("call_tgt", 32'(bus.idex_call_tgt), 32'h5ABC);
    chk("call_ex", 32'(bus.idex_ex), 32'h1F1);
    for (int k = 0; k < 2; k++) begin
      s_stall = 1; s_instr = 16'h0312; s_pc = 16'h0100; step();
      chk("stall_hold_stall", 32'(stall_seen), 32'h1);
      chk("stall_hold_valid", 32'(bus.idex_valid), 32'h1);
      chk("stall_hold_tgt", 32'(bus.idex_call_tgt), 32'h5ABC);
      chk("stall_hold_r0", 32'(bus.idex_r0data), 32'hFFFF);
    end

    // HALT accepted, then sticky
    set_idle(); s_valid = 1; s_instr = 16'hF000; step();
    chk("halt_bubble", 32'(bus.idex_valid), 32'h0);
    chk("halt_rise", 32'(bus.halted), 32'h1);
    for (int k = 0; k < 3; k++) begin
      s_instr = 16'h0312; step();
      chk("halted_stall", 32'(stall_seen), 32'h1);
      chk("halted_bubble", 32'(bus.idex_valid), 32'h0);
      chk("halted_sticky", 32'(bus.halted), 32'h1);
    end

    // Reset mid-stall with a live ID/EX entry
    do_reset();
    set_idle(); s_valid = 1; s_instr = 16'h0312; step();
    s_instr = 16'h1123; s_mr = 1; s_exrd = 4'd2;
    do_reset();
    chk("rst_mid_r0data", 32'(bus.idex_r0data), 32'h0);

    // Randomized traffic
    halt_cycles = 0;
    for (int n = 0; n < 2500; n++) begin
      rand_stim();
      if (mhalted) halt_cycles++;
      if (halt_cycles > 4 || $urandom_range(0, 199) == 0) begin
        halt_cycles = 0;
        do_reset();
      end else begin
        step();
      end
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the 5-stage pipelined CPU. It contains the register file, the instruction decoder, load-use hazard detection, the registered ID/EX pipeline boundary and a sticky halt state machine. It sits between the IF/ID register and the EX stage, and receives the write-back port from WB. It generalises the earlier combinational decode slice in data width, register count and stack-pointer selection, and adds stall, flush, bypass and halt behaviour.

## Interface
- DATA_W, 16, datapath/register width (≥16)
- NREGS, 16, register count (power of 2, ≤16; 4-bit fields use low log2(NREGS) bits)
- SP_REG, 14, register index used as stack pointer by CALL/RET
- SP_RESET, 16'hFFFF (DATA_W wide), reset value of SP_REG
- Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_valid  in  1  IF/ID holds a real instruction
- if_instr  in  16  instruction word
- if_pc_inc  in  DATA_W  PC+1 of that instruction
- ex_stall  in  1  EX cannot accept; hold ID/EX
- flush  in  1  squash instruction in ID (taken branch/call/ret)
- ex_mem_read  in  1  instruction now in EX is a load
- ex_rd  in  4  destination of instruction in EX
- wb_we, wb_addr, wb_data  in  1/4/DATA_W  register write port
- id_stall  out  1  hold PC and IF/ID
- halted  out  1  HALT retired from decode; sticky
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc_inc, idex_r0data, idex_r1data, idex_imm, idex_offset  out  DATA_W each
- idex_call_tgt  out  DATA_W  {pc_inc[DATA_W-1:12], instr[11:0]}
- idex_rs, idex_rt, idex_rd  out  4 each
- idex_ex  out  9  {call, pc_to_mem, sp_addr, alu_src[1:0], alu_op[3:0]}
- idex_m  out  3  {branch, mem_write, mem_read}
- idex_wb  out  3  {ret, mem_to_reg, reg_write}

## Operation
- Opcodes instr[15:12]: 0 ADD, 1 SUB, 2 NAND, 3 XOR, 4 INC, 5 SRA, 6 SRL, 7 SLL, 8 LW, 9 SW, A LHB, B LLB, C B, D CALL, E RET, F HALT.
- Control values:
  - ALU ops (0-3): reg_write=1, alu_op=opcode.
  - INC, shifts: alu_src=01, rt not read; INC uses alu_op=ADD.
  - LW: reg_write, mem_read, mem_to_reg, alu_src=01, alu_op=ADD, rt not read.
  - SW: mem_write, alu_src=01, alu_op=ADD, read_rd.
  - LHB/LLB: reg_write, alu_src=10, alu_op=opcode, read_rd.
  - B: branch, no reads.
  - CALL: reg_write, mem_write, pc_to_mem, sp_addr, call, alu_src=11, alu_op=SUB.
  - RET: reg_write, mem_read, sp_addr, ret, alu_src=11, alu_op=ADD.
  - HALT: all zero.
- Read addresses: r0 = sp_addr ? SP_REG : rs; r1 = read_rd ? rd : rt.
- Immediates:
  - offset = sext(instr[7:0]).
  - imm = sext(instr[3:0]), except LHB/LLB where imm = zext(instr[7:0]).
- Register file:
  - Register 0 reads as 0; writes to register 0 are ignored.
  - Write on clk when wb_we=1.
  - Same-cycle read of wb_addr (≠0, wb_we=1) returns wb_data (write-through bypass).
- Load-use hazard is asserted when all of the following hold:
  - if_valid, ex_mem_read, ex_rd≠0;
  - (r0 used and r0==ex_rd) or (r1 used and r1==ex_rd).
- id_stall = hazard | ex_stall | (state==HALTED). Forced 0 while flush=1 and while rst_n=0.
- ID/EX update, in priority order:
  1. flush → bubble.
  2. ex_stall → hold.
  3. hazard or HALTED → bubble.
  4. Otherwise load decode; idex_valid=if_valid.
- Bubble definition: idex_valid=0, idex_ex/m/wb=0; data fields don't-care, driven 0.
- FSM:
  - RUN→HALTED when a valid HALT is accepted (no flush, no ex_stall, no hazard). The HALT itself enters ID/EX as a bubble.
  - HALTED is left only by reset. flush has no effect in HALTED.
- halted = (state==HALTED).

## Timing
- Reset (async, rst_n low): all ID/EX outputs 0, idex_valid=0, state RUN, halted=0; registers 0 except SP_REG=SP_RESET.
- Decode-to-ID/EX latency: 1 cycle.
- Register file: write at edge N is visible to a read in cycle N+1; visible in cycle N via the bypass.
- Load-use stall: exactly 1 bubble per hazard. The next cycle's EX is no longer a load, so the hazard clears.
- halted rises 1 cycle after the HALT edge. id_stall stays high from then on.
- flush together with hazard: bubble, id_stall=0 (IF redirect proceeds).
- flush together with HALT: halt not taken.
- Reset asserted mid-stall: all state clears immediately; no partial ID/EX update.

## Test plan
- Reset, then ADD r3,r1,r2 with r1=5, r2=7 (preloaded via WB) → next edge idex_valid=1, r0data=5, r1data=7, idex_wb=001, alu_op=0.
- WB writes r4=16'h1234 in the same cycle ID decodes XOR r5,r4,r4 → idex_r0data=16'h1234 (bypass). Writing r0=9 → reading r0 returns 0.
- ex_mem_read=1, ex_rd=2, ID holds SUB r1,r2,r3 → id_stall=1 for 1 cycle, one bubble (idex_valid=0), then SUB issues.
- flush=1 with hazard present → id_stall=0, bubble. flush with HALT → halted stays 0.
- HALT accepted → halted=1 next cycle, id_stall=1, continuous bubbles; stays until rst_n low.
- CALL 0xABC with pc_inc=16'h5001, SP=16'hFFFF → r0data=16'hFFFF, idex_call_tgt=16'h5ABC, idex_ex call/pc_to_mem/sp_addr=1, alu_src=11, alu_op=1. ex_stall=1 for 2 cycles → ID/EX held constant.
